// File: rtl/img2col_pkg.sv
// Shared types and defaults for the img2col PU sequencer.
//   seq_state_e    : sequencer FSM states
//   KS_DEF, DW_DEF : default kernel side and pixel width
//   beats_per_col  : pixel-pair beats needed to fill one KS-pixel column
package img2col_pkg;

  localparam int unsigned KS_DEF = 5;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFire,
    StWait,
    StPresent,
    StDone
  } seq_state_e;

  function automatic int unsigned beats_per_col(input int unsigned ks);
    return (ks + 1) / 2;
  endfunction

endpackage

// File: rtl/img2col_beat_pack.sv
// Packs accepted pixel-pair beats into PU new-register writes.
//   clk, rst       : clock, asynchronous active-high reset
//   pix            : register index of the first pixel of this beat
//   hs             : beat handshake this cycle
//   data1, data2   : beat pixels
//   adrs1/2, new1/2: registered write addresses and data (valid with wr_g)
//   wr_g           : registered per-register write strobes, 0 without a write
//   col_complete   : combinational, this handshake fills the column
module img2col_beat_pack
  import img2col_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned KS = KS_DEF,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pix,
  input  logic          hs,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [AW-1:0] adrs1,
  output logic [AW-1:0] adrs2,
  output logic [DW-1:0] new1,
  output logic [DW-1:0] new2,
  output logic [KS-1:0] wr_g,
  output logic          col_complete
);

  logic          tail;
  logic [KS-1:0] wr_g_d;

  // Odd tail: only one register remains in the column, second pixel is dropped.
  assign tail         = (pix == AW'(KS - 1));
  assign col_complete = hs & (tail | (pix == AW'(KS - 2)));

  always_comb begin
    wr_g_d = '0;
    for (int i = 0; i < KS; i++) begin
      wr_g_d[i] = hs & ((pix == AW'(i)) | (~tail & ((pix + AW'(1)) == AW'(i))));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adrs1 <= '0;
      adrs2 <= '0;
      new1  <= '0;
      new2  <= '0;
      wr_g  <= '0;
    end else begin
      wr_g <= wr_g_d;
      if (hs) begin
        adrs1 <= pix;
        new1  <= data1;
        if (!tail) begin
          adrs2 <= pix + AW'(1);
          new2  <= data2;
        end
      end
    end
  end

endmodule

// File: rtl/img2col_pu_sequencer.sv
// Sequences one img2col PU across an image row: loads each KS-pixel column
// from a pixel-pair stream, fires the PU, and offers complete KSxKS windows
// downstream.
//   clk, rst            : clock, asynchronous active-high reset
//   go, cfg_cols        : start a row of cfg_cols columns (cfg_cols >= KS)
//   busy, cfg_err       : row in progress; pulse on a rejected go
//   s_valid/ready/data* : pixel-pair input stream
//   pu_new*/adrs*/wr_g  : PU new-register write port
//   pu_start/round/nbr  : PU fire pulse, column index, neighbour-valid flag
//   win_valid/win_ready : window handshake to the MAC stage
//   row_done            : pulse after the last column
module img2col_pu_sequencer
  import img2col_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned KS     = KS_DEF,
  parameter int unsigned AW     = 5,
  parameter int unsigned PU_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [5:0]    cfg_cols,
  output logic          busy,
  output logic          cfg_err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data1,
  input  logic [DW-1:0] s_data2,
  output logic [DW-1:0] pu_new1,
  output logic [DW-1:0] pu_new2,
  output logic [AW-1:0] pu_adrs1,
  output logic [AW-1:0] pu_adrs2,
  output logic [KS-1:0] pu_wr_g,
  output logic          pu_start,
  output logic [5:0]    pu_round,
  output logic          pu_nbr_flag,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          row_done
);

  localparam int unsigned LatW = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

  seq_state_e    state_q;
  logic [5:0]    col_q;
  logic [5:0]    cols_q;
  logic [AW-1:0] pix_q;
  logic [LatW-1:0] lat_q;

  logic       hs;
  logic       col_complete;
  logic       last_col;
  seq_state_e adv_state;

  // s_ready is only ever high in LOAD, so no beat is accepted elsewhere.
  assign hs        = s_valid & s_ready;
  assign last_col  = (col_q == (cols_q - 6'd1));
  assign adv_state = last_col ? StDone : StLoad;

  img2col_beat_pack #(
    .DW (DW),
    .KS (KS),
    .AW (AW)
  ) u_pack (
    .clk          (clk),
    .rst          (rst),
    .pix          (pix_q),
    .hs           (hs),
    .data1        (s_data1),
    .data2        (s_data2),
    .adrs1        (pu_adrs1),
    .adrs2        (pu_adrs2),
    .new1         (pu_new1),
    .new2         (pu_new2),
    .wr_g         (pu_wr_g),
    .col_complete (col_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      cols_q      <= '0;
      pix_q       <= '0;
      lat_q       <= '0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      s_ready     <= 1'b0;
      pu_start    <= 1'b0;
      pu_round    <= '0;
      pu_nbr_flag <= 1'b0;
      win_valid   <= 1'b0;
      row_done    <= 1'b0;
    end else begin
      cfg_err  <= 1'b0;
      pu_start <= 1'b0;
      row_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            if (cfg_cols < 6'(KS)) begin
              cfg_err <= 1'b1;
            end else begin
              cols_q  <= cfg_cols;
              busy    <= 1'b1;
              col_q   <= '0;
              pix_q   <= '0;
              s_ready <= 1'b1;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (hs) begin
            if (col_complete) begin
              s_ready <= 1'b0;
              state_q <= StFire;
            end else begin
              pix_q <= pix_q + AW'(2);
            end
          end
        end
        StFire: begin
          pu_start    <= 1'b1;
          pu_round    <= col_q;
          pu_nbr_flag <= (col_q != 6'd0);
          lat_q       <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          if (lat_q == LatW'(PU_LAT - 1)) begin
            if (col_q < 6'(KS - 1)) begin
              // Priming column: window not yet complete, advance directly.
              col_q    <= col_q + 6'd1;
              pix_q    <= '0;
              state_q  <= adv_state;
              s_ready  <= ~last_col;
              busy     <= ~last_col;
              row_done <= last_col;
            end else begin
              win_valid <= 1'b1;
              state_q   <= StPresent;
            end
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StPresent: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            col_q     <= col_q + 6'd1;
            pix_q     <= '0;
            state_q   <= adv_state;
            s_ready   <= ~last_col;
            busy      <= ~last_col;
            row_done  <= last_col;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img2col_pu_sequencer.sv
module tb_img2col_pu_sequencer;
  import img2col_pkg::*;

  localparam int DW     = 16;
  localparam int KS     = 5;
  localparam int AW     = 5;
  localparam int PU_LAT = 2;

  logic          clk;
  logic          rst;
  logic          go;
  logic [5:0]    cfg_cols;
  logic          busy;
  logic          cfg_err;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data1;
  logic [DW-1:0] s_data2;
  logic [DW-1:0] pu_new1;
  logic [DW-1:0] pu_new2;
  logic [AW-1:0] pu_adrs1;
  logic [AW-1:0] pu_adrs2;
  logic [KS-1:0] pu_wr_g;
  logic          pu_start;
  logic [5:0]    pu_round;
  logic          pu_nbr_flag;
  logic          win_valid;
  logic          win_ready;
  logic          row_done;

  img2col_pu_sequencer #(
    .DW     (DW),
    .KS     (KS),
    .AW     (AW),
    .PU_LAT (PU_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .cfg_cols    (cfg_cols),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data1     (s_data1),
    .s_data2     (s_data2),
    .pu_new1     (pu_new1),
    .pu_new2     (pu_new2),
    .pu_adrs1    (pu_adrs1),
    .pu_adrs2    (pu_adrs2),
    .pu_wr_g     (pu_wr_g),
    .pu_start    (pu_start),
    .pu_round    (pu_round),
    .pu_nbr_flag (pu_nbr_flag),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .row_done    (row_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [59:0] all_outs;
  assign all_outs = {busy, cfg_err, s_ready, pu_new1, pu_new2, pu_adrs1, pu_adrs2, pu_wr_g,
                     pu_start, pu_round, pu_nbr_flag, win_valid, row_done};

  // vmode: 0 = s_valid always high, 1 = random 50%
  // rmode: 0 = win_ready tied 1, 1 = random, 2 = hold 0 for 10 cycles on first window
  typedef struct {
    int cols;
    int vmode;
    int rmode;
    int exp_beats;
    int exp_wins;
  } vec_t;

  vec_t tbl[5];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard state
  bit          mon_en = 0;
  bit          pend = 0;
  logic [4:0]  exp_wr, exp_a1, exp_a2;
  logic [15:0] exp_n1, exp_n2;
  int          pix_m, cyc, starts, wins, dones, beats_acc;
  int          last_start, last_round, last_tail;
  logic        wv_prev;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        chk("wr_g", pu_wr_g, exp_wr);
        chk("adrs1", pu_adrs1, exp_a1);
        chk("new1", pu_new1, exp_n1);
        if (exp_wr != 5'b10000) begin
          chk("adrs2", pu_adrs2, exp_a2);
          chk("new2", pu_new2, exp_n2);
        end else begin
          last_tail = cyc;
        end
      end else if (pu_wr_g != '0) begin
        chk("stray_wr_g", pu_wr_g, 0);
      end
      pend = 0;
      if (s_valid && s_ready) begin
        pend   = 1;
        exp_a1 = 5'(pix_m);
        exp_a2 = 5'(pix_m + 1);
        exp_n1 = s_data1;
        exp_n2 = s_data2;
        if (pix_m == 4) begin
          exp_wr = 5'b10000;
          pix_m  = 0;
        end else begin
          exp_wr = 5'b00011 << pix_m;
          pix_m  = pix_m + 2;
        end
        beats_acc++;
      end
      if (pu_start) begin
        chk("round", pu_round, starts);
        chk("nbr_flag", pu_nbr_flag, (starts != 0));
        chk("start_after_tail", cyc - last_tail, 1);
        last_start = cyc;
        last_round = pu_round;
        starts++;
      end
      if (win_valid && !wv_prev) begin
        chk("win_latency", cyc - last_start, PU_LAT);
        chk("win_round_ge4", (last_round >= 4), 1);
      end
      if (win_valid && win_ready) wins++;
      if (row_done) dones++;
      wv_prev = win_valid;
      cyc++;
    end
  end

  task automatic drive_beat(input int vmode, input int beat);
    s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    s_data1 = 16'(2 * beat + 1);
    s_data2 = 16'(2 * beat + 2);
  endtask

  task automatic run_row(input vec_t v);
    int beat;
    bit done;
    int hold;
    bit rel;
    int starts_hold;
    starts = 0; wins = 0; dones = 0; beats_acc = 0; pix_m = 0; pend = 0;
    wv_prev = 0; cyc = 0; last_start = -100; last_tail = -100; last_round = 0;
    mon_en = 1;
    go = 1; cfg_cols = 6'(v.cols); s_valid = 0;
    win_ready = (v.rmode == 0);
    step();
    go = 0;
    chk("busy_after_go", busy, 1);
    chk("s_ready_after_go", s_ready, 1);
    beat = 0; done = 0; hold = 0; rel = 0; starts_hold = 0;
    drive_beat(v.vmode, beat);
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (s_valid && s_ready) beat++;
      if (row_done) done = 1;
      @(posedge clk);
      #1;
      if (rel) begin
        chk("release_s_ready", s_ready, 1);
        chk("release_win_valid", win_valid, 0);
        rel = 0;
      end
      drive_beat(v.vmode, beat);
      case (v.rmode)
        0: win_ready = 1'b1;
        1: win_ready = 1'($urandom_range(0, 1));
        default: begin
          if (hold == 0 && win_valid) begin
            starts_hold = starts;
            chk("bp_s_ready", s_ready, 0);
            win_ready = 1'b0;
            hold = 1;
          end else if (hold >= 1 && hold < 10) begin
            chk("bp_win_valid_held", win_valid, 1);
            chk("bp_s_ready", s_ready, 0);
            win_ready = 1'b0;
            hold++;
          end else if (hold == 10) begin
            chk("bp_win_valid_held", win_valid, 1);
            chk("bp_no_extra_start", starts, starts_hold);
            win_ready = 1'b1;
            rel = 1;
            hold++;
          end else begin
            win_ready = (hold > 10);
          end
        end
      endcase
    end
    s_valid = 0;
    mon_en = 0;
    chk("row_timeout", done, 1);
    chk("busy_after_row", busy, 0);
    chk("row_done_one_cycle", row_done, 0);
    chk("beats", beats_acc, v.exp_beats);
    chk("windows", wins, v.exp_wins);
    chk("starts", starts, v.cols);
    chk("row_done_count", dones, 1);
  endtask

  initial begin
    tbl[0] = '{cols: 5, vmode: 0, rmode: 0, exp_beats: 15, exp_wins: 1};
    tbl[1] = '{cols: 7, vmode: 0, rmode: 0, exp_beats: 21, exp_wins: 3};
    tbl[2] = '{cols: 6, vmode: 1, rmode: 0, exp_beats: 18, exp_wins: 2};
    tbl[3] = '{cols: 6, vmode: 0, rmode: 2, exp_beats: 18, exp_wins: 2};
    tbl[4] = '{cols: 9, vmode: 1, rmode: 1, exp_beats: 27, exp_wins: 5};

    rst = 1; go = 0; cfg_cols = '0; s_valid = 0; s_data1 = '0; s_data2 = '0; win_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs, 60'd0);
    rst = 0;
    step();

    // Abort mid-LOAD after two beats.
    go = 1; cfg_cols = 6'd6;
    step();
    go = 0;
    s_valid = 1; s_data1 = 16'd1; s_data2 = 16'd2;
    step();
    s_data1 = 16'd3; s_data2 = 16'd4;
    step();
    s_valid = 0;
    chk("pre_abort_wr_g", pu_wr_g, 5'b01100);
    chk("pre_abort_adrs1", pu_adrs1, 2);
    rst = 1;
    #1;
    chk("mid_row_reset_outputs", all_outs, 60'd0);
    step();
    rst = 0;
    step();

    // Rejected go.
    go = 1; cfg_cols = 6'd4;
    step();
    go = 0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_s_ready", s_ready, 0);
    step();
    chk("cfg_err_one_cycle", cfg_err, 0);
    chk("cfg_err_still_idle", busy, 0);

    for (int i = 0; i < 5; i++) begin
      run_row(tbl[i]);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img2col_pu_sequencer.md
Name: img2col_pu_sequencer

Overview:
Controller that sequences one img2col processing unit (PU) across one image row.
- Accepts a valid/ready stream of pixel pairs from the AXI read side.
- Packs each 5-pixel column into the PU's new-pixel register file: write addresses, write strobes and data.
- Fires the PU once per column and drives the round number and neighbour flag.
- Presents each completed 5x5 window to the downstream MAC stage with a valid/ready handshake.

Parameters:
DW, 16, pixel data width
KS, 5, kernel side; pixels per column and new-register depth
AW, 5, PU register address width
PU_LAT, 2, cycles from pu_start until the PU window output is stable (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
go  in  1  start-row pulse
cfg_cols  in  6  columns in this row; sampled on accepted go
busy  out  1  high from accepted go until row_done
cfg_err  out  1  1-cycle pulse when go is rejected
s_valid  in  1  pixel-pair beat valid
s_ready  out  1  beat accept
s_data1  in  DW  first pixel of beat
s_data2  in  DW  second pixel of beat
pu_new1  out  DW  PU write data 1
pu_new2  out  DW  PU write data 2
pu_adrs1  out  AW  PU write address 1
pu_adrs2  out  AW  PU write address 2
pu_wr_g  out  KS  per-register write strobe mask
pu_start  out  1  PU fire pulse
pu_round  out  6  current column index
pu_nbr_flag  out  1  neighbour data valid for this round
win_valid  out  1  window available on PU outputs
win_ready  in  1  downstream accepts window
row_done  out  1  1-cycle pulse after the last column

Behaviour:
- All outputs are registered. On reset every output is 0, the FSM is IDLE, and all counters are 0.
- rst asserted mid-row aborts immediately. No partial state survives.
- FSM states: IDLE, LOAD, FIRE, WAIT, PRESENT, DONE.
- IDLE:
  - go with cfg_cols < KS: pulse cfg_err, stay in IDLE.
  - Otherwise latch cfg_cols, set busy, set col=0 and pix=0, go to LOAD.
  - go in any other state is ignored.
- LOAD:
  - s_ready=1. A handshake (s_valid & s_ready) in cycle n writes in cycle n+1:
    - pu_adrs1=pix, pu_adrs2=pix+1
    - pu_new1=s_data1, pu_new2=s_data2
    - pu_wr_g has bits pix and pix+1 set
  - pix advances by 2.
  - When pix==KS-1 (odd tail), only bit pix is set, s_data2 is discarded, and pix advances by 1.
  - For KS=5 a column takes 3 beats (2+2+1).
  - pu_wr_g is 0 in every cycle without a write.
  - s_ready drops in the cycle after the column-completing handshake. Go to FIRE.
- FIRE:
  - pu_start=1 for exactly 1 cycle, the cycle after the final write strobe.
  - pu_round=col.
  - pu_nbr_flag=(col!=0); it is held stable until the next FIRE.
- WAIT:
  - Count PU_LAT cycles from pu_start.
  - If col < KS-1 (priming column, window incomplete): skip PRESENT.
  - Otherwise go to PRESENT.
- PRESENT:
  - win_valid=1 is held until win_ready.
  - win_ready may already be high: the transfer completes in the first cycle win_valid is high.
  - win_valid drops the cycle after the transfer.
- Column advance:
  - After PRESENT or a skipped PRESENT: col++, pix=0.
  - If col was cfg_cols-1, go to DONE; else go to LOAD.
- DONE: row_done=1 and busy=0 in the same cycle, then IDLE.
- Counts:
  - Windows per row = cfg_cols-KS+1.
  - Beats per row = cfg_cols*ceil(KS/2).
- col is 6-bit and cfg_cols<=63, so there is no wrap.
- s_valid outside LOAD is never accepted.

Decomposition:
- Package img2col_pkg holds:
  - seq_state_e enum (IDLE, LOAD, FIRE, WAIT, PRESENT, DONE)
  - localparams KS_DEF=5 and DW_DEF=16
  - function beats_per_col(KS)=(KS+1)/2
- One natural sub-module: img2col_beat_pack.
  - Inputs: pix, handshake, data.
  - Outputs: registered adrs/new/wr_g, plus col_complete.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-LOAD (cfg_cols=6, after 2 beats) -> all outputs 0, then go restarts the row cleanly with pix=0.
- go with cfg_cols=4 -> cfg_err 1 cycle, busy stays 0, s_ready stays 0. go with cfg_cols=5 -> busy=1.
- cfg_cols=5, beats (1,2),(3,4),(5,6) with s_valid always high:
  - pu_wr_g sequence 00011, 01100, 10000.
  - Last beat: pu_adrs1=4, pu_new1=5; pixel 6 is discarded.
  - pu_start the cycle after.
  - 15 beats total; exactly 1 win_valid, at col 4; row_done once.
- cfg_cols=7, win_ready tied 1:
  - pu_round 0..6.
  - pu_nbr_flag 0 at round 0, 1 thereafter.
  - 3 windows, win_valid at rounds 4, 5, 6, each 1 cycle wide, PU_LAT=2 cycles after pu_start.
- Backpressure:
  - win_ready held 0 for 10 cycles -> win_valid held, s_ready 0, no extra pu_start.
  - Release -> next LOAD.
- s_valid toggled randomly, 50% duty -> identical write sequence and window count; no handshake while s_ready=0.
